disp_scan: RTL

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/fre_disp_pkg.sv | 40 ++++
 rtl/bcd_seg_dec.sv | 25 ++
 rtl/disp_scan.sv | 98 +++++++++
 3 files changed

// File: rtl/fre_disp_pkg.sv
// Shared constants and types for the eight-digit multiplexed 7-segment display scanner.
// Segment codes are active low in {dp,g,f,e,d,c,b,a} order with the decimal point off.
package fre_disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  // One frame's worth of display data, frozen at the frame boundary.
  typedef struct packed {
    logic                        over;
    logic [NUM_DIGITS-1:0][3:0]  digits;
  } snap_t;

  // Marks every zero digit above the most significant nonzero digit; digit 1 is never marked.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
    input logic [NUM_DIGITS-1:0][3:0] d
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero_above;
    mask           = '0;
    all_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero_above = all_zero_above && (d[k] == 4'd0);
      mask[k]        = all_zero_above;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to active-low 7-segment decode; codes 10-15 blank, dp always off.
module bcd_seg_dec
  import fre_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Eight-digit time-multiplexed 7-segment scanner with per-frame snapshot and dead time.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits of each snapshot.
module disp_scan
  import fre_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] num_in1,
  input  logic [3:0] num_in2,
  input  logic [3:0] num_in3,
  input  logic [3:0] num_in4,
  input  logic [3:0] num_in5,
  input  logic [3:0] num_in6,
  input  logic [3:0] num_in7,
  input  logic [3:0] num_in8,
  input  logic       over_in,
  output logic [7:0] seg_out,
  output logic [7:0] an_out
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  snap_t                 snap_q, snap_d, live;
  logic [NUM_DIGITS-1:0] blank_d;
  logic                  wrap, frame_end;
  logic [3:0]            digit;
  logic [7:0]            dec_seg, seg_d, an_d;

  bcd_seg_dec u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  // Outputs are computed from next-state values so they register on the same edge
  // as the prescaler, index and snapshot they describe.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    wrap        = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end   = wrap && (idx_q == 3'd7);
    live.over   = over_in;
    live.digits = {num_in8, num_in7, num_in6, num_in5,
                   num_in4, num_in3, num_in2, num_in1};
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    idx_d       = wrap ? idx_q + 3'd1 : idx_q;
    snap_d      = frame_end ? live : snap_q;
    digit       = snap_d.digits[idx_d];
    seg_d       = blank_d[idx_d] ? SEG_BLANK : dec_seg;
    if (snap_d.over && (idx_d == 3'd7)) begin
      seg_d[7] = 1'b0;
    end
    an_d = (cnt_d < CW'(DEAD_CYC)) ? 8'hFF : ~(8'h01 << idx_d);
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q;

  // The mask is evaluated only when a new snapshot is taken and held with it.
  always_comb begin
    blank_d = frame_end ? lead_zero_mask(live.digits) : blank_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  always_comb begin
    blank_d = '0;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      an_out  <= 8'hFF;
      seg_out <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_out  <= an_d;
      seg_out <= seg_d;
    end
  end

endmodule
